rf_write_port_arbiter: RTL and testbench
========================================

// Module: rf_write_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order write-back stage and a
//  long-latency unit (mul/div) that returns results out of band. Pipeline write-back has
//  priority. Long-latency results wait in a small FIFO. A starvation counter freezes write-back
//  so queued results always drain. Sits between the write-back stage / LU and the regfile.
// PARAMETERS
//  DEPTH         2   LU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4   consecutive cycles a non-empty FIFO may be denied before pipe_stall
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  wb_reg_write in   1   write-back stage write enable
//  wb_rd        in   5   write-back destination register
//  wb_data      in   32  write-back value
//  lu_valid     in   1   LU result valid
//  lu_ready     out  1   FIFO can accept; equals !full
//  lu_rd        in   5   LU destination register
//  lu_data      in   32  LU result value
//  rf_we        out  1   regfile write enable
//  rf_rd        out  5   regfile write address
//  rf_wd        out  32  regfile write data
//  pipe_stall   out  1   freeze WB stage this cycle (its write is not taken)
//  busy_mask    out  32  bit r set while any FIFO entry targets r; bit 0 always 0
//  lu_pending   out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset: FIFO empty, rd/wr pointers 0, starve_cnt 0. Outputs then: lu_ready=1, rf_we=0,
//    pipe_stall=0, busy_mask=0, lu_pending=0. rf_rd/rf_wd=0 when rf_we=0.
//  - wb_act = wb_reg_write && wb_rd!=0. Writes to x0 never reach the port (rf_we=0).
//  - pipe_stall = !empty && starve_cnt>=STARVE_LIMIT. It is combinational and does not depend
//    on wb inputs.
//  - Grant, combinational, same cycle:
//      pipe_stall=1          -> port = FIFO head; pop.
//      else wb_act=1         -> port = {wb_rd,wb_data}; FIFO held.
//      else !empty           -> port = FIFO head; pop.
//      else                  -> rf_we=0.
//  - WB latency is 0: its write commits at the same edge. An LU result pushed at edge N reaches
//    the port no earlier than cycle N+1. There is no bypass from lu_* to the port.
//  - Push: lu_valid && lu_ready && lu_rd!=0 enqueues at the edge. lu_valid with lu_rd==0 is
//    accepted (handshake completes) but discarded.
//  - lu_ready = !full, registered state only. When full, a same-cycle pop does not open
//    lu_ready; the LU holds lu_valid/lu_rd/lu_data stable until accepted.
//  - Push and pop in the same cycle: both take effect and occupancy is unchanged.
//    Pointers wrap modulo DEPTH.
//  - starve_cnt:
//      cleared on any pop or when the FIFO is empty.
//      incremented when !empty and not popped.
//      saturates at STARVE_LIMIT.
//  - busy_mask is recomputed from valid FIFO entries, so a popped entry clears its bit after
//    the edge. Duplicate rd entries keep the bit set until the last one drains. The hazard unit
//    uses busy_mask to block RAW/WAW. The arbiter does not reorder writes to the same rd.
//  - rst mid-operation flushes all queued LU results. Results are lost; the LU is reset by the
//    same rst.
// TESTING
//  1. WB only:
//     wb_reg_write=1, wb_rd=5, wb_data=0xDEADBEEF
//     -> same cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; pipe_stall=0.
//  2. x0 filter:
//     wb_rd=0 with wb_reg_write=1 -> rf_we=0.
//     LU push rd=0 -> lu_ready handshake ok, lu_pending stays 0.
//  3. LU drain on idle WB:
//     push rd=7, data=0x1234, wb idle
//     -> next cycle rf_we=1, rf_rd=7, rf_wd=0x1234; busy_mask[7] 1 -> 0 after that edge.
//  4. Starvation, DEPTH=2, LIMIT=4:
//     push rd=9, wb_act held high
//     -> WB wins 4 cycles; 5th cycle pipe_stall=1, port = rd 9.
//     -> next cycle pipe_stall=0 and WB resumes.
//  5. Full FIFO:
//     push rd=3 then rd=4 with WB busy -> lu_ready=0, lu_pending=2.
//     Third lu_valid held until after first pop.
//     Drain order 3 then 4.
//  6. Reset mid-operation:
//     rst with 2 entries queued -> next cycle lu_pending=0, busy_mask=0, lu_ready=1, rf_we=0.

Source files
------------

// File: rtl/rf_write_port_arbiter.sv
// rtl/rf_write_port_arbiter.sv - register-file write port arbiter between write-back and a long-latency unit
// Write-back has priority; LU results queue in a FIFO and a starvation counter forces a drain.
module rf_write_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wb_reg_write,
    input  logic [4:0]              i_wb_rd,
    input  logic [31:0]             i_wb_data,
    input  logic                    i_lu_valid,
    output logic                    o_lu_ready,
    input  logic [4:0]              i_lu_rd,
    input  logic [31:0]             i_lu_data,
    output logic                    o_rf_we,
    output logic [4:0]              o_rf_rd,
    output logic [31:0]             o_rf_wd,
    output logic                    o_pipe_stall,
    output logic [31:0]             o_busy_mask,
    output logic [$clog2(DEPTH):0]  o_lu_pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_rd   [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;

    logic        w_empty;
    logic        w_full;
    logic        w_wb_act;
    logic        w_stall;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_busy_mask;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_wb_act = i_wb_reg_write && (i_wb_rd != 5'd0);
    assign w_stall  = !w_empty && (r_starve >= SW'(STARVE_LIMIT));
    assign w_pop    = w_stall || (!w_wb_act && !w_empty);
    // Zero-rd results complete the handshake but are never stored.
    assign w_push   = i_lu_valid && !w_full && (i_lu_rd != 5'd0);

    always_comb begin
        w_busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                w_busy_mask[r_rd[r_rd_ptr + AW'(i)]] = 1'b1;
            end
        end
        w_busy_mask[0] = 1'b0;
    end

    always_comb begin
        o_rf_we = 1'b0;
        o_rf_rd = 5'd0;
        o_rf_wd = 32'd0;
        if (w_pop) begin
            o_rf_we = 1'b1;
            o_rf_rd = r_rd[r_rd_ptr];
            o_rf_wd = r_data[r_rd_ptr];
        end else if (w_wb_act) begin
            o_rf_we = 1'b1;
            o_rf_rd = i_wb_rd;
            o_rf_wd = i_wb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_rd[r_wr_ptr]   <= i_lu_rd;
            r_data[r_wr_ptr] <= i_lu_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (r_starve < SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    assign o_lu_ready   = !w_full;
    assign o_pipe_stall = w_stall;
    assign o_busy_mask  = w_busy_mask;
    assign o_lu_pending = r_count;
endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// tb/tb_rf_write_port_arbiter.sv - self-checking bench for rf_write_port_arbiter
module tb_rf_write_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_data = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        pipe_stall;
    logic [31:0] busy_mask;
    logic [1:0]  lu_pending;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    rf_write_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_reg_write(wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_lu_valid(lu_valid), .o_lu_ready(lu_ready), .i_lu_rd(lu_rd), .i_lu_data(lu_data),
        .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_wd(rf_wd),
        .o_pipe_stall(pipe_stall), .o_busy_mask(busy_mask), .o_lu_pending(lu_pending)
    );

    // Scoreboard: every port write must match the next expected {rd,data}.
    always @(negedge clk) begin
        logic [36:0] e;
        if (!rst && rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL port_write unexpected: got rd=%0d wd=%h, none expected", rf_rd, rf_wd);
            end else begin
                e = exp_q.pop_front();
                if ({rf_rd, rf_wd} !== e) begin
                    n_err++;
                    $display("FAIL port_write: got rd=%0d wd=%h, expected rd=%0d wd=%h",
                             rf_rd, rf_wd, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({lu_ready, rf_we, pipe_stall, busy_mask, lu_pending, rf_rd, rf_wd} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 5'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: ready=%b we=%b stall=%b busy=%h pend=%0d rd=%0d wd=%h, expected 1 0 0 0 0 0 0",
                     lu_ready, rf_we, pipe_stall, busy_mask, lu_pending, rf_rd, rf_wd);
        end
        cyc();
    endtask

    task automatic test_wb_only();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || pipe_stall !== 1'b0) begin
            n_err++;
            $display("FAIL wb_only: we=%b stall=%b, expected 1 0", rf_we, pipe_stall);
        end
        cyc();
        wb_rd = 5'd31; wb_data = 32'h0;
        exp_q.push_back({5'd31, 32'h0});
        cyc();
        idle_inputs();
    endtask

    task automatic test_x0_filter();
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'h55AA55AA;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL x0_wb: we=%b, expected 0", rf_we);
        end
        cyc();
        idle_inputs();
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h77;
        @(negedge clk);
        n_cmp++;
        if (lu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL x0_lu_ready: ready=%b, expected 1", lu_ready);
        end
        cyc();
        lu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (lu_pending !== 2'd0 || rf_we !== 1'b0 || busy_mask !== 32'd0) begin
            n_err++;
            $display("FAIL x0_lu_discard: pend=%0d we=%b busy=%h, expected 0 0 0", lu_pending, rf_we, busy_mask);
        end
        cyc();
    endtask

    task automatic test_lu_drain();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL lu_no_bypass: we=%b, expected 0", rf_we);
        end
        exp_q.push_back({5'd7, 32'h1234});
        cyc();
        lu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || busy_mask !== 32'h80 || lu_pending !== 2'd1) begin
            n_err++;
            $display("FAIL lu_drain: we=%b busy=%h pend=%0d, expected 1 00000080 1", rf_we, busy_mask, lu_pending);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (busy_mask !== 32'd0 || lu_pending !== 2'd0) begin
            n_err++;
            $display("FAIL lu_drained: busy=%h pend=%0d, expected 0 0", busy_mask, lu_pending);
        end
        cyc();
    endtask

    task automatic test_starvation();
        wb_reg_write = 1'b1; wb_rd = 5'd10; wb_data = 32'hA000;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h9999;
        exp_q.push_back({5'd10, 32'hA000});
        cyc();
        lu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wb_data = 32'hA000 + 32'(k);
            exp_q.push_back({5'd10, 32'hA000 + 32'(k)});
            @(negedge clk);
            n_cmp++;
            if (pipe_stall !== 1'b0) begin
                n_err++;
                $display("FAIL starve_wb_wins[%0d]: stall=%b, expected 0", k, pipe_stall);
            end
            cyc();
        end
        wb_data = 32'hA005;
        exp_q.push_back({5'd9, 32'h9999});
        @(negedge clk);
        n_cmp++;
        if (pipe_stall !== 1'b1) begin
            n_err++;
            $display("FAIL starve_stall: stall=%b, expected 1", pipe_stall);
        end
        cyc();
        wb_data = 32'hA006;
        exp_q.push_back({5'd10, 32'hA006});
        @(negedge clk);
        n_cmp++;
        if (pipe_stall !== 1'b0 || lu_pending !== 2'd0) begin
            n_err++;
            $display("FAIL starve_resume: stall=%b pend=%0d, expected 0 0", pipe_stall, lu_pending);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_full();
        wb_reg_write = 1'b1; wb_rd = 5'd11; wb_data = 32'hB0;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h333;
        exp_q.push_back({5'd11, 32'hB0});
        cyc();
        wb_data = 32'hB1;
        lu_rd = 5'd4; lu_data = 32'h444;
        exp_q.push_back({5'd11, 32'hB1});
        cyc();
        wb_reg_write = 1'b0;
        lu_rd = 5'd6; lu_data = 32'h666;
        exp_q.push_back({5'd3, 32'h333});
        @(negedge clk);
        n_cmp++;
        if (lu_ready !== 1'b0 || lu_pending !== 2'd2 || busy_mask !== 32'h18) begin
            n_err++;
            $display("FAIL full_state: ready=%b pend=%0d busy=%h, expected 0 2 00000018", lu_ready, lu_pending, busy_mask);
        end
        cyc();
        exp_q.push_back({5'd4, 32'h444});
        @(negedge clk);
        n_cmp++;
        if (lu_ready !== 1'b1 || lu_pending !== 2'd1) begin
            n_err++;
            $display("FAIL full_reopen: ready=%b pend=%0d, expected 1 1", lu_ready, lu_pending);
        end
        cyc();
        lu_valid = 1'b0;
        exp_q.push_back({5'd6, 32'h666});
        @(negedge clk);
        n_cmp++;
        if (lu_pending !== 2'd1 || busy_mask !== 32'h40) begin
            n_err++;
            $display("FAIL full_push_pop: pend=%0d busy=%h, expected 1 00000040", lu_pending, busy_mask);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_dup_rd();
        wb_reg_write = 1'b1; wb_rd = 5'd12; wb_data = 32'hC0;
        lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h801;
        exp_q.push_back({5'd12, 32'hC0});
        cyc();
        wb_data = 32'hC1; lu_data = 32'h802;
        exp_q.push_back({5'd12, 32'hC1});
        cyc();
        idle_inputs();
        exp_q.push_back({5'd8, 32'h801});
        cyc();
        exp_q.push_back({5'd8, 32'h802});
        @(negedge clk);
        n_cmp++;
        if (busy_mask !== 32'h100) begin
            n_err++;
            $display("FAIL dup_rd_hold: busy=%h, expected 00000100", busy_mask);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (busy_mask !== 32'd0) begin
            n_err++;
            $display("FAIL dup_rd_clear: busy=%h, expected 0", busy_mask);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        wb_reg_write = 1'b1; wb_rd = 5'd13; wb_data = 32'hD0;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'h2020;
        exp_q.push_back({5'd13, 32'hD0});
        cyc();
        wb_data = 32'hD1; lu_rd = 5'd21; lu_data = 32'h2121;
        exp_q.push_back({5'd13, 32'hD1});
        cyc();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (lu_pending !== 2'd0 || busy_mask !== 32'd0 || lu_ready !== 1'b1 || rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: pend=%0d busy=%h ready=%b we=%b, expected 0 0 1 0",
                     lu_pending, busy_mask, lu_ready, rf_we);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_x0_filter();
        test_lu_drain();
        test_starvation();
        test_full();
        test_dup_rd();
        test_reset_mid();
        cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
